// File: rtl/nand_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nand_pkg
//  Purpose  : Shared definitions for the NAND read bridge: read-sequencer
//             state encoding and default bus widths.
//  Contents : c_DEF_DATA_W  default NAND data bus width
//             c_DEF_CNT_W   default byte-count width
//             rd_state_t    read sequencer states (IDLE/ISSUE/WAIT/FIN)
//  Revision : 1.0  initial release
// ============================================================================
package nand_pkg;

   localparam int c_DEF_DATA_W = 8;
   localparam int c_DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_FIN   = 2'd3
   } rd_state_t;

endpackage : nand_pkg
`default_nettype wire

// File: rtl/nand_rd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : nand_rd_fifo
//  Purpose  : Synchronous show-ahead FIFO holding captured NAND bytes.
//  Ports    : CLK        system clock, rising edge
//             RST        synchronous active-high reset (flushes pointers)
//             push       write push_data (ignored when full)
//             push_data  byte to store
//             pop        drop the head entry (ignored when empty)
//             full       no free entries
//             empty      no stored entries
//             head_data  current head entry, zero while empty
//  Params   : DATA_W, DEPTH (power of two, >= 2)
//  Revision : 1.0  initial release
// ============================================================================
module nand_rd_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] head_data
);

   localparam int c_AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   // One extra pointer bit tells a wrapped (full) FIFO from an empty one.
   logic [c_AW:0]     r_wr_ptr;
   logic [c_AW:0]     r_rd_ptr;
   logic              w_do_push;
   logic              w_do_pop;

   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage is not reset; stale contents are hidden by the empty gate below.
   always_ff @(posedge CLK) begin
      if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
   end

   assign head_data = empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

endmodule : nand_rd_fifo
`default_nettype wire

// File: rtl/nand_rd_capture.sv
`default_nettype none
// ============================================================================
//  Module   : nand_rd_capture
//  Purpose  : NAND page-read sequencer and data capture. Issues one RD_Start
//             per byte to the read-strobe generator, samples DQ_In while REn
//             is low, pushes each byte on the REn rising edge into a capture
//             FIFO drained through a valid/ready interface.
//  Ports    : CLK, RST            clock / synchronous active-high reset
//             Start, Byte_Num     transfer request and length (IDLE only)
//             Busy, Done, Err     status (Err sticky until next Start)
//             RD_Start, RD_Over   strobe generator handshake
//             REn_In, DQ_In       device REn and synchronised data bus
//             Out_Data/Valid/Ready  host-side stream
//             Csum                16-bit byte sum (optional)
//  Options  : NAND_RD_CAPTURE_CSUM_EN adds the Csum output and its adder.
//  Revision : 1.0  initial release
// ============================================================================
module nand_rd_capture
   import nand_pkg::*;
#(
   parameter int DATA_W     = c_DEF_DATA_W,
   parameter int CNT_W      = c_DEF_CNT_W,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Start,
   input  logic [CNT_W-1:0]  Byte_Num,
   output logic              Busy,
   output logic              Done,
   output logic              Err,
   output logic              RD_Start,
   input  logic              RD_Over,
   input  logic              REn_In,
   input  logic [DATA_W-1:0] DQ_In,
   output logic [DATA_W-1:0] Out_Data,
   output logic              Out_Valid,
   input  logic              Out_Ready
`ifdef NAND_RD_CAPTURE_CSUM_EN
   ,
   output logic [15:0]       Csum
`endif
);

   rd_state_t         r_state;
   logic [CNT_W-1:0]  r_remaining;
   logic              r_got_byte;
   logic              r_ren_d;
   logic [DATA_W-1:0] r_hold;
   logic              r_busy;
   logic              r_done;
   logic              r_err;

   logic              w_full;
   logic              w_empty;
   logic              w_rise;
   logic              w_push;
   logic              w_pop;

   assign w_rise = ~r_ren_d & REn_In;
   // Only the first REn rising edge of a strobe carries the byte.
   assign w_push = (r_state == ST_WAIT) & w_rise & ~r_got_byte;
   assign w_pop  = ~w_empty & Out_Ready;

   // Decoded from registered state so the strobe lines up with the ISSUE
   // cycle; gating on full keeps any push from ever overflowing the FIFO.
   assign RD_Start  = (r_state == ST_ISSUE) & ~w_full;
   assign Busy      = r_busy;
   assign Done      = r_done;
   assign Err       = r_err;
   assign Out_Valid = ~w_empty;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_remaining <= '0;
         r_got_byte  <= 1'b0;
         r_ren_d     <= 1'b1;
         r_hold      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_ren_d <= REn_In;
         if (!REn_In) r_hold <= DQ_In;
         r_done <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (Start) begin
                  r_err       <= 1'b0;
                  r_busy      <= 1'b1;
                  r_remaining <= Byte_Num;
                  if (Byte_Num == '0) begin
                     r_state <= ST_FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_ISSUE;
                  end
               end
            end

            ST_ISSUE: begin
               if (!w_full) begin
                  r_got_byte <= 1'b0;
                  r_state    <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (w_push) r_got_byte <= 1'b1;
               if (RD_Over) begin
                  // A push in the same cycle as RD_Over still counts.
                  if (!r_got_byte && !w_push) r_err <= 1'b1;
                  r_remaining <= r_remaining - CNT_W'(1);
                  if (r_remaining == CNT_W'(1)) begin
                     r_state <= ST_FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_ISSUE;
                  end
               end
            end

            ST_FIN: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef NAND_RD_CAPTURE_CSUM_EN
   logic [15:0] r_csum;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_csum <= '0;
      end else if ((r_state == ST_IDLE) && Start) begin
         r_csum <= '0;
      end else if (w_push) begin
         r_csum <= r_csum + 16'(r_hold);
      end
   end

   assign Csum = r_csum;
`endif

   nand_rd_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .push      (w_push),
      .push_data (r_hold),
      .pop       (w_pop),
      .full      (w_full),
      .empty     (w_empty),
      .head_data (Out_Data)
   );

endmodule : nand_rd_capture
`default_nettype wire

// File: tb/tb_nand_rd_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nand_rd_capture
//  Purpose  : Self-checking bench for nand_rd_capture. A behavioural strobe
//             generator answers RD_Start, records every byte it really
//             delivers into an expected queue, and a scoreboard compares the
//             drained stream against it.
//  Options  : NAND_RD_CAPTURE_CSUM_EN also checks Csum.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nand_rd_capture;

   localparam int DATA_W     = 8;
   localparam int CNT_W      = 16;
   localparam int FIFO_DEPTH = 4;

   logic              CLK       = 1'b0;
   logic              RST       = 1'b1;
   logic              Start     = 1'b0;
   logic [CNT_W-1:0]  Byte_Num  = '0;
   logic              RD_Over   = 1'b0;
   logic              REn_In    = 1'b1;
   logic [DATA_W-1:0] DQ_In     = '0;
   logic              Out_Ready = 1'b0;
   logic              Busy, Done, Err, RD_Start, Out_Valid;
   logic [DATA_W-1:0] Out_Data;
`ifdef NAND_RD_CAPTURE_CSUM_EN
   logic [15:0]       Csum;
`endif

   nand_rd_capture #(
      .DATA_W(DATA_W), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .CLK(CLK), .RST(RST), .Start(Start), .Byte_Num(Byte_Num),
      .Busy(Busy), .Done(Done), .Err(Err), .RD_Start(RD_Start),
      .RD_Over(RD_Over), .REn_In(REn_In), .DQ_In(DQ_In),
      .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready)
`ifdef NAND_RD_CAPTURE_CSUM_EN
      , .Csum(Csum)
`endif
   );

   initial forever #5 CLK = ~CLK;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          strobe_cnt = 0, inj_cnt = 0, inj_at = -1;
   int          rs_cnt = 0, done_cnt = 0, pop_cnt = 0;
   int          rdy_mode = 1;
   bit          fixed_tim = 1'b1, rand_inj = 1'b0;
   int unsigned csum_tot = 0, csum_base = 0;
   int          rs_base = 0, done_base = 0, pop_base = 0, inj_base = 0;
   logic [7:0]  dq_src[$];
   logic [7:0]  exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- strobe generator model (tREA = 2 cycles) -------------
   task automatic serve_one();
      int         lat;
      bit         inj, same, dbl;
      logic [7:0] b;
      lat  = fixed_tim ? 0 : int'($urandom_range(0, 2));
      inj  = (strobe_cnt == inj_at) || (rand_inj && ($urandom_range(0, 7) == 0));
      same = fixed_tim ? 1'b0 : 1'($urandom_range(0, 1));
      dbl  = fixed_tim ? 1'b0 : ($urandom_range(0, 3) == 0);
      strobe_cnt++;
      repeat (1 + lat) @(negedge CLK);
      if (inj) begin
         inj_cnt++;
         repeat (2) @(negedge CLK);
      end else begin
         if (dq_src.size() != 0) b = dq_src.pop_front();
         else                    b = 8'($urandom);
         REn_In = 1'b0;
         DQ_In  = b;
         repeat (2) @(negedge CLK);
         REn_In = 1'b1;
         DQ_In  = 8'($urandom);
         exp_q.push_back(b);
         csum_tot += b;
         if (dbl) begin
            @(negedge CLK); REn_In = 1'b0;
            @(negedge CLK); REn_In = 1'b1;
         end
         if (!same) @(negedge CLK);
      end
      RD_Over = 1'b1;
      @(negedge CLK);
      RD_Over = 1'b0;
   endtask

   initial begin : strobe_gen
      forever begin
         @(negedge CLK);
         while (RD_Start === 1'b1) serve_one();
      end
   end

   initial begin : rdy_drv
      forever begin
         @(posedge CLK); #1;
         case (rdy_mode)
            0:       Out_Ready = 1'b0;
            1:       Out_Ready = 1'b1;
            default: Out_Ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin : monitors
      logic [31:0] e;
      forever begin
         @(negedge CLK);
         if (RD_Start === 1'b1) rs_cnt++;
         if (Done === 1'b1)     done_cnt++;
         if (RST === 1'b0 && Out_Valid === 1'b1 && Out_Ready === 1'b1) begin
            e = (exp_q.size() == 0) ? 32'h100 : 32'(exp_q.pop_front());
            check("out_data", 32'(Out_Data), e);
            pop_cnt++;
         end
      end
   end

   // ---------------- directed helpers -------------------------------------
   task automatic start_xfer(input int n);
      @(posedge CLK); #1;
      Start     = 1'b1;
      Byte_Num  = CNT_W'(n);
      csum_base = csum_tot;
      rs_base   = rs_cnt;
      done_base = done_cnt;
      pop_base  = pop_cnt;
      inj_base  = inj_cnt;
      @(posedge CLK); #1;
      Start    = 1'b0;
      Byte_Num = CNT_W'($urandom);
   endtask

   task automatic wait_done(input int budget, input string tag);
      int k = 0;
      @(negedge CLK);
      while (Done !== 1'b1 && k < budget) begin
         @(negedge CLK);
         k++;
      end
      check({tag, "_done_seen"}, 32'(k < budget), 1);
      check({tag, "_busy_at_done"}, 32'(Busy), 1);
`ifdef NAND_RD_CAPTURE_CSUM_EN
      check({tag, "_csum"}, 32'(Csum), (csum_tot - csum_base) & 32'hFFFF);
`endif
      @(negedge CLK);
      check({tag, "_busy_after"}, 32'(Busy), 0);
      check({tag, "_done_pulses"}, 32'(done_cnt - done_base), 1);
   endtask

   task automatic drain(input int budget, input string tag);
      int k = 0;
      rdy_mode = 1;
      while (exp_q.size() != 0 && k < budget) begin
         @(negedge CLK);
         k++;
      end
      repeat (2) @(negedge CLK);
      check({tag, "_drained"}, 32'(exp_q.size()), 0);
      check({tag, "_valid_low"}, 32'(Out_Valid), 0);
   endtask

   // ---------------- main sequence ----------------------------------------
   initial begin : main
      int k, n;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      check("rst_busy",     32'(Busy), 0);
      check("rst_done",     32'(Done), 0);
      check("rst_err",      32'(Err), 0);
      check("rst_rd_start", 32'(RD_Start), 0);
      check("rst_valid",    32'(Out_Valid), 0);
      check("rst_data",     32'(Out_Data), 0);

      // Four bytes, fixed generator timing, consumer always ready.
      dq_src = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      rdy_mode = 1;
      start_xfer(4);
      @(negedge CLK);
      check("t1_busy_n1", 32'(Busy), 1);
      check("t1_rdstart_n1", 32'(RD_Start), 1);
      wait_done(100, "t1");
      check("t1_rd_starts", 32'(rs_cnt - rs_base), 4);
      check("t1_err", 32'(Err), 0);
      drain(50, "t1");
      check("t1_pops", 32'(pop_cnt - pop_base), 4);

      // Zero-length read: Done straight away, no strobes.
      start_xfer(0);
      @(negedge CLK);
      check("t2_done", 32'(Done), 1);
      check("t2_busy", 32'(Busy), 1);
      @(negedge CLK);
      check("t2_busy_off", 32'(Busy), 0);
      check("t2_done_off", 32'(Done), 0);
      check("t2_rd_starts", 32'(rs_cnt - rs_base), 0);

      // Six bytes into a four-deep FIFO with the consumer stalled.
      rdy_mode = 0;
      start_xfer(6);
      repeat (60) @(negedge CLK);
      check("t3_rs_stall", 32'(rs_cnt - rs_base), 4);
      check("t3_rs_low", 32'(RD_Start), 0);
      check("t3_busy", 32'(Busy), 1);
      check("t3_valid", 32'(Out_Valid), 1);
      rdy_mode = 1;
      wait_done(200, "t3");
      check("t3_rd_starts", 32'(rs_cnt - rs_base), 6);
      drain(50, "t3");
      check("t3_pops", 32'(pop_cnt - pop_base), 6);

      // RD_Over with no REn edge on byte 2 of 3.
      inj_at = strobe_cnt + 1;
      start_xfer(3);
      wait_done(200, "t4");
      inj_at = -1;
      check("t4_err", 32'(Err), 1);
      drain(50, "t4");
      check("t4_pops", 32'(pop_cnt - pop_base), 2);
      start_xfer(1);
      @(negedge CLK);
      check("t4_err_clear", 32'(Err), 0);
      wait_done(100, "t4b");
      drain(50, "t4b");

`ifdef NAND_RD_CAPTURE_CSUM_EN
      dq_src = '{8'hFF, 8'hFF, 8'h02};
      start_xfer(3);
      wait_done(100, "csum");
      check("csum_value", 32'(Csum), 32'h0200);
      drain(50, "csum");
`endif

      // Reset while waiting on byte 3 of 8.
      rdy_mode = 0;
      start_xfer(8);
      k = 0;
      while ((rs_cnt - rs_base) < 3 && k < 200) begin
         @(negedge CLK);
         k++;
      end
      check("t5_reached_b3", 32'(k < 200), 1);
      check("t5_valid_pre", 32'(Out_Valid), 1);
      @(posedge CLK); #1 RST = 1'b1;
      @(posedge CLK); #1 RST = 1'b0;
      @(negedge CLK);
      check("t5_busy", 32'(Busy), 0);
      check("t5_valid", 32'(Out_Valid), 0);
      check("t5_data", 32'(Out_Data), 0);
      check("t5_done", 32'(Done), 0);
      repeat (30) @(negedge CLK);
      check("t5_no_reissue", 32'(rs_cnt - rs_base), 3);
      check("t5_busy_stay", 32'(Busy), 0);
      exp_q.delete();
      rdy_mode = 1;

      // Randomised transfers: timing, back-pressure, data, missing edges.
      fixed_tim = 1'b0;
      rand_inj  = 1'b1;
      for (int t = 0; t < 10; t++) begin
         rdy_mode = 2;
         n = int'($urandom_range(1, 9));
         start_xfer(n);
         wait_done(800, "rnd");
         check("rnd_rd_starts", 32'(rs_cnt - rs_base), 32'(n));
         check("rnd_err", 32'(Err), 32'(inj_cnt != inj_base));
         drain(100, "rnd");
         check("rnd_pops", 32'(pop_cnt - pop_base), 32'(n - (inj_cnt - inj_base)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_nand_rd_capture
`default_nettype wire
